// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and BOOT/RUN/HALT control.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        fetch_fault
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalled
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] instr_r, instr_s;
  logic [31:0] pc4_r, pc4_s;
  logic        valid_r, valid_s;
  logic        fault_r, fault_s;
  logic [31:0] pc_plus4_s;
  logic        pc_bad_s;

  // Misaligned or beyond the end of instruction memory.
  function automatic logic pc_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || ({1'b0, pc} >= IMEM_BYTES);
  endfunction

  assign imem_addr   = pc_r;
  assign pc_plus4_s  = pc_r + 32'd4;
  assign pc_bad_s    = pc_fault(pc_r);
  assign ifid_instr  = instr_r;
  assign ifid_pc4    = pc4_r;
  assign ifid_valid  = valid_r;
  assign fetch_fault = fault_r;

  // Next-state and next IF/ID contents.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    instr_s = instr_r;
    pc4_s   = pc4_r;
    valid_s = valid_r;
    fault_s = fault_r;
    case (state_r)
      // Settle cycle: memory output for the new PC is not valid yet.
      ST_BOOT: begin
        state_s = ST_RUN;
        valid_s = 1'b0;
      end
      ST_RUN: begin
        if (redirect) begin
          pc_s    = redirect_pc;
          instr_s = 32'd0;
          valid_s = 1'b0;
          state_s = ST_BOOT;
        end else if (stall) begin
          state_s = ST_RUN;
        end else if (pc_bad_s) begin
          state_s = ST_HALT;
          fault_s = 1'b1;
          valid_s = 1'b0;
        end else begin
          instr_s = imem_instr;
          pc4_s   = pc_plus4_s;
          valid_s = 1'b1;
          pc_s    = pc_plus4_s;
        end
      end
      ST_HALT: begin
        valid_s = 1'b0;
      end
      default: begin
        state_s = ST_HALT;
        valid_s = 1'b0;
        fault_s = 1'b1;
      end
    endcase
  end

  // Fetch state and IF/ID registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_BOOT;
      pc_r    <= RESET_PC;
      instr_r <= 32'd0;
      pc4_r   <= 32'd0;
      valid_r <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      instr_r <= instr_s;
      pc4_r   <= pc4_s;
      valid_r <= valid_s;
      fault_r <= fault_s;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetched_r;
  logic [31:0] stalled_r;

  assign perf_fetched = fetched_r;
  assign perf_stalled = stalled_r;

  // Count captures and stall cycles taken in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_r <= 32'd0;
      stalled_r <= 32'd0;
    end else if (state_r == ST_RUN && !redirect) begin
      if (stall) begin
        stalled_r <= stalled_r + 32'd1;
      end else if (!pc_bad_s) begin
        fetched_r <= fetched_r + 32'd1;
      end
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_if_stage.sv
// Table-driven check of if_stage against hand-computed per-cycle expectations.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_pc, imem_addr, imem_instr;
  logic [31:0] ifid_instr, ifid_pc4;
  logic        ifid_valid, fetch_fault;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stalled;
`endif

  int total = 0;
  int bad   = 0;

  if_stage #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
    .fetch_fault(fetch_fault)
`ifdef IF_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stalled(perf_stalled)
`endif
  );

  always #5 clk = ~clk;

  // Memory word i holds 0x1000_0000 | i; reads outside the 4 KiB array return a marker.
  always_comb begin
    if (imem_addr < 32'h0000_1000) imem_instr = 32'h1000_0000 | {22'd0, imem_addr[11:2]};
    else                           imem_instr = 32'hDEAD_BEEF;
  end

  typedef struct {
    logic        rst, stl, rdr;
    logic [31:0] rpc;
    logic [31:0] e_instr, e_pc4;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_fault;
  } vec_t;

  vec_t tbl[32];
  int   n = 0;

  task automatic add(input logic rst, input logic stl, input logic rdr, input logic [31:0] rpc,
                     input logic [31:0] ei, input logic [31:0] ep4, input logic ev,
                     input logic [31:0] epc, input logic ef);
    tbl[n] = '{rst, stl, rdr, rpc, ei, ep4, ev, epc, ef};
    n++;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;

    //   rst   stl   rdr   rpc            instr          pc4            vld   pc             flt
    add(1'b1, 1'b0, 1'b0, 32'h0,        32'h0,         32'h0,         1'b0, 32'h0,         1'b0); // reset
    add(1'b0, 1'b1, 1'b1, 32'h80,       32'h0,         32'h0,         1'b0, 32'h0,         1'b0); // boot ignores inputs
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h1000_0000, 32'h4,         1'b1, 32'h4,         1'b0); // A
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h1000_0001, 32'h8,         1'b1, 32'h8,         1'b0); // B
    add(1'b0, 1'b1, 1'b0, 32'h0,        32'h1000_0001, 32'h8,         1'b1, 32'h8,         1'b0); // stall x3
    add(1'b0, 1'b1, 1'b0, 32'h0,        32'h1000_0001, 32'h8,         1'b1, 32'h8,         1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0,        32'h1000_0001, 32'h8,         1'b1, 32'h8,         1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h1000_0002, 32'hC,         1'b1, 32'hC,         1'b0); // C
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h1000_0003, 32'h10,        1'b1, 32'h10,        1'b0); // D
    add(1'b0, 1'b1, 1'b1, 32'h40,       32'h0,         32'h10,        1'b0, 32'h40,        1'b0); // redirect beats stall
    add(1'b0, 1'b1, 1'b1, 32'h80,       32'h0,         32'h10,        1'b0, 32'h40,        1'b0); // settle ignores inputs
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h1000_0010, 32'h44,        1'b1, 32'h44,        1'b0); // word 16
    add(1'b0, 1'b0, 1'b1, 32'h42,       32'h0,         32'h44,        1'b0, 32'h42,        1'b0); // misaligned target
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         32'h44,        1'b0, 32'h42,        1'b0); // settle
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         32'h44,        1'b0, 32'h42,        1'b1); // fault -> HALT
    add(1'b0, 1'b0, 1'b1, 32'h0,        32'h0,         32'h44,        1'b0, 32'h42,        1'b1); // redirect ignored
    add(1'b0, 1'b1, 1'b0, 32'h0,        32'h0,         32'h44,        1'b0, 32'h42,        1'b1); // stall ignored
    add(1'b1, 1'b0, 1'b0, 32'h0,        32'h0,         32'h0,         1'b0, 32'h0,         1'b0); // reset clears HALT
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         32'h0,         1'b0, 32'h0,         1'b0); // boot
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h1000_0000, 32'h4,         1'b1, 32'h4,         1'b0); // A again
    add(1'b0, 1'b0, 1'b1, 32'hFF8,      32'h0,         32'h4,         1'b0, 32'hFF8,       1'b0); // jump near end
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         32'h4,         1'b0, 32'hFF8,       1'b0); // settle
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h1000_03FE, 32'hFFC,       1'b1, 32'hFFC,       1'b0); // word 1022
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h1000_03FF, 32'h1000,      1'b1, 32'h1000,      1'b0); // word 1023
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h1000_03FF, 32'h1000,      1'b0, 32'h1000,      1'b1); // 0x1000 faults
    add(1'b1, 1'b1, 1'b1, 32'h40,       32'h0,         32'h0,         1'b0, 32'h0,         1'b0); // reset beats all
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         32'h0,         1'b0, 32'h0,         1'b0); // boot
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h1000_0000, 32'h4,         1'b1, 32'h4,         1'b0); // A

    for (int i = 0; i < n; i++) begin
      reset = tbl[i].rst; stall = tbl[i].stl; redirect = tbl[i].rdr; redirect_pc = tbl[i].rpc;
      tick();
      chk("ifid_instr",  i, ifid_instr,           tbl[i].e_instr);
      chk("ifid_pc4",    i, ifid_pc4,             tbl[i].e_pc4);
      chk("ifid_valid",  i, {31'd0, ifid_valid},  {31'd0, tbl[i].e_valid});
      chk("imem_addr",   i, imem_addr,            tbl[i].e_pc);
      chk("fetch_fault", i, {31'd0, fetch_fault}, {31'd0, tbl[i].e_fault});
    end

`ifdef IF_PERF_CNT_EN
    // Five fetches and two stall cycles after a fresh reset.
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; tick();
    reset = 1'b0; tick();
    for (int k = 0; k < 3; k++) tick();
    stall = 1'b1; tick(); tick();
    stall = 1'b0; tick(); tick();
    chk("perf_fetched", 100, perf_fetched, 32'd5);
    chk("perf_stalled", 100, perf_stalled, 32'd2);
    reset = 1'b1; tick();
    chk("perf_fetched_rst", 101, perf_fetched, 32'd0);
    chk("perf_stalled_rst", 101, perf_stalled, 32'd0);
    reset = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
